junction_controller: RTL and testbench
======================================

// Module: junction_controller
// PURPOSE
//  Sequences a two-approach UK road junction: north-south (NS) and east-west (EW).
//  Each approach drives its own red/amber/green lamp set.
//  Every phase dwells for a fixed, parameterised number of cycles.
//  All-red clearance separates the approaches; a latched pedestrian request inserts an all-red walk phase.
//  The block sits above the lamp outputs and is the only sequencer of them in the design.
// PARAMETERS
//  T_GREEN     default 8   green dwell per approach, cycles (>=1)
//  T_AMBER     default 3   amber dwell, cycles (>=1)
//  T_RED_AMBER default 2   red+amber dwell, cycles (>=1)
//  T_ALLRED    default 2   all-red clearance dwell, cycles (>=1)
//  T_WALK      default 6   pedestrian walk dwell, cycles (>=1)
//  CNT_W       default 8   dwell counter width; every T_* must be <= 2**CNT_W
// PORTS
//  clk       in   1  system clock, rising edge
//  rst_n     in   1  asynchronous active-low reset
//  en        in   1  1 = sequence runs; 0 = state and counter frozen, outputs held
//  ped_req   in   1  pedestrian request, level or pulse, sampled every cycle
//  ns_red    out  1  NS red lamp
//  ns_amber  out  1  NS amber lamp
//  ns_green  out  1  NS green lamp
//  ew_red    out  1  EW red lamp
//  ew_amber  out  1  EW amber lamp
//  ew_green  out  1  EW green lamp
//  ped_walk  out  1  pedestrian walk signal
//  ped_ack   out  1  one-cycle pulse when a request is granted
//  state_o   out  4  current FSM state encoding, for debug
// BEHAVIOUR
//  - One clock; reset is asynchronous and active-low.
//  - All outputs are registered and decoded from the state register. No combinational path runs from any input to any output.
//  - States, each held for exactly T_x cycles of en=1, then the listed next state:
//      NS_GRN(0)  NS=001 EW=100  T_GREEN      -> NS_AMB
//      NS_AMB(1)  NS=010 EW=100  T_AMBER      -> CLR_A
//      CLR_A(2)   NS=100 EW=100  T_ALLRED     -> WALK_A if pend, else EW_RA
//      WALK_A(3)  all red, ped_walk=1, T_WALK -> EW_RA
//      EW_RA(4)   NS=100 EW=110  T_RED_AMBER  -> EW_GRN
//      EW_GRN(5)  NS=100 EW=001  T_GREEN      -> EW_AMB
//      EW_AMB(6)  NS=100 EW=010  T_AMBER      -> CLR_B
//      CLR_B(7)   all red        T_ALLRED     -> WALK_B if pend, else NS_RA
//      WALK_B(8)  all red, ped_walk=1, T_WALK -> NS_RA
//      NS_RA(9)   NS=110 EW=100  T_RED_AMBER  -> NS_GRN
//    Lamp triples above are {red,amber,green}.
//  - Dwell counter:
//    - Loads T_x-1 on entry to each state and decrements while en=1.
//    - When the counter is 0 and en=1, the FSM advances at that edge.
//  - Illegal state encodings (10..15) go to CLR_B with the counter loaded at T_ALLRED-1. The next cycle shows all red.
//  - Reset values:
//    - state = CLR_B, counter = T_ALLRED-1, pend = 0.
//    - Lamp outputs: ns_red = ew_red = 1, all other lamps 0.
//    - ped_walk = 0, ped_ack = 0, state_o = 7.
//  - Exactly one lamp per approach is lit, except during red+amber. NS and EW are never both non-red.
//  - Pedestrian request latch (pend):
//    - Set when ped_req=1 and the current state is not WALK_A or WALK_B. ped_req during WALK_A or WALK_B is discarded.
//    - On the edge where CLR_A or CLR_B exits into WALK_A or WALK_B: pend clears and ped_ack=1 for that one cycle.
//    - If ped_req=1 on that same edge, the request is absorbed by the grant and pend stays 0.
//  - en=0:
//    - State, counter and outputs all hold.
//    - pend still latches requests.
//    - ped_ack does not pulse while en=0.
//  - rst_n low mid-phase: immediate return to the reset values; any pending request is lost.
// TESTING
//  Bench parameters: T_GREEN=4, T_AMBER=2, T_RED_AMBER=1, T_ALLRED=1, T_WALK=3.
//  1 Reset release, en=1, no ped_req -> state_o sequence: 7,9,0,0,0,0,1,1,2,4,5,5,5,5,6,6,7,9. Lamps match the table every cycle.
//  2 ped_req pulse during NS_GRN -> CLR_A is followed by 3 cycles of WALK_A with ped_walk=1. ped_ack pulses once, in the first WALK_A cycle. The next CLR_B goes straight to NS_RA.
//  3 ped_req held high through WALK_A -> exactly one grant. The held request re-latches after WALK_A ends and is granted at CLR_B.
//  4 en=0 for 5 cycles in the middle of EW_GRN -> state and lamps frozen. EW_GRN still totals 4 cycles with en=1. A ped_req during the freeze is granted at the next CLR.
//  5 rst_n asserted asynchronously between clock edges during EW_AMB with pend=1 -> outputs go all-red immediately, pend=0, state_o=7. The sequence restarts as in test 1.
//  6 Every cycle of all tests -> assert the NS/EW conflict property, and assert ped_walk=1 only when all lamps are red.

Source files
------------

// File: rtl/junction_controller_if.sv
// ----------------------------------------------------------------------------
// junction_controller_if
//   Bundles the control inputs and lamp/pedestrian outputs of the junction
//   controller so they travel as a single port.
//   master : drives en/ped_req, observes lamps, walk, ack and debug state
//   slave  : the controller side (receives en/ped_req, drives everything else)
//   Signals:
//     en        sequence run enable
//     ped_req   pedestrian request (level or pulse)
//     ns_*      north-south red/amber/green lamps
//     ew_*      east-west red/amber/green lamps
//     ped_walk  pedestrian walk signal
//     ped_ack   one-cycle grant pulse
//     state_o   current FSM state encoding (debug)
// ----------------------------------------------------------------------------
interface junction_controller_if;
    logic       en;
    logic       ped_req;
    logic       ns_red;
    logic       ns_amber;
    logic       ns_green;
    logic       ew_red;
    logic       ew_amber;
    logic       ew_green;
    logic       ped_walk;
    logic       ped_ack;
    logic [3:0] state_o;

    modport master (
        output en, ped_req,
        input  ns_red, ns_amber, ns_green, ew_red, ew_amber, ew_green,
        input  ped_walk, ped_ack, state_o
    );

    modport slave (
        input  en, ped_req,
        output ns_red, ns_amber, ns_green, ew_red, ew_amber, ew_green,
        output ped_walk, ped_ack, state_o
    );
endinterface

// File: rtl/junction_controller.sv
// ----------------------------------------------------------------------------
// junction_controller
//   Sequences a two-approach junction (NS / EW) through green, amber,
//   all-red clearance, optional pedestrian walk, and red+amber phases. Each
//   phase dwells a fixed number of enabled cycles. A latched pedestrian
//   request inserts an all-red walk phase after the next clearance.
//   Ports:
//     clk    system clock, rising edge
//     rst_n  asynchronous active-low reset
//     bus    junction_controller_if.slave (en, ped_req in; lamps, ped_walk,
//            ped_ack, state_o out)
//   All outputs come straight from registers.
// ----------------------------------------------------------------------------
module junction_controller #(
    parameter int T_GREEN     = 8,
    parameter int T_AMBER     = 3,
    parameter int T_RED_AMBER = 2,
    parameter int T_ALLRED    = 2,
    parameter int T_WALK      = 6,
    parameter int CNT_W       = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    junction_controller_if.slave bus
);

    typedef enum logic [3:0] {
        NS_GRN = 4'd0,
        NS_AMB = 4'd1,
        CLR_A  = 4'd2,
        WALK_A = 4'd3,
        EW_RA  = 4'd4,
        EW_GRN = 4'd5,
        EW_AMB = 4'd6,
        CLR_B  = 4'd7,
        WALK_B = 4'd8,
        NS_RA  = 4'd9
    } state_t;

    state_t             state_q, state_d, nxt;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               pend_q, pend_d;
    logic               ack_q, ack_d;
    // {ns_red, ns_amber, ns_green, ew_red, ew_amber, ew_green, ped_walk}
    logic [6:0]         out_q, out_d;

    function automatic logic [CNT_W-1:0] dwell(input state_t s);
        case (s)
            NS_GRN, EW_GRN: dwell = CNT_W'(T_GREEN - 1);
            NS_AMB, EW_AMB: dwell = CNT_W'(T_AMBER - 1);
            NS_RA,  EW_RA:  dwell = CNT_W'(T_RED_AMBER - 1);
            WALK_A, WALK_B: dwell = CNT_W'(T_WALK - 1);
            default:        dwell = CNT_W'(T_ALLRED - 1);
        endcase
    endfunction

    function automatic logic [6:0] decode(input state_t s);
        case (s)
            NS_GRN:         decode = 7'b001_100_0;
            NS_AMB:         decode = 7'b010_100_0;
            NS_RA:          decode = 7'b110_100_0;
            EW_RA:          decode = 7'b100_110_0;
            EW_GRN:         decode = 7'b100_001_0;
            EW_AMB:         decode = 7'b100_010_0;
            WALK_A, WALK_B: decode = 7'b100_100_1;
            default:        decode = 7'b100_100_0;
        endcase
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= CLR_B;
            cnt_q   <= CNT_W'(T_ALLRED - 1);
            pend_q  <= 1'b0;
            ack_q   <= 1'b0;
            out_q   <= 7'b100_100_0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            pend_q  <= pend_d;
            ack_q   <= ack_d;
            out_q   <= out_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        pend_d  = pend_q;
        ack_d   = 1'b0;
        nxt     = state_q;

        if (bus.ped_req && state_q != WALK_A && state_q != WALK_B)
            pend_d = 1'b1;

        case (state_q)
            NS_GRN:  nxt = NS_AMB;
            NS_AMB:  nxt = CLR_A;
            CLR_A:   nxt = pend_q ? WALK_A : EW_RA;
            WALK_A:  nxt = EW_RA;
            EW_RA:   nxt = EW_GRN;
            EW_GRN:  nxt = EW_AMB;
            EW_AMB:  nxt = CLR_B;
            CLR_B:   nxt = pend_q ? WALK_B : NS_RA;
            WALK_B:  nxt = NS_RA;
            NS_RA:   nxt = NS_GRN;
            default: nxt = CLR_B;
        endcase

        if (state_q > NS_RA) begin
            // Corrupted encoding: recover to clearance regardless of en.
            state_d = CLR_B;
            cnt_d   = dwell(CLR_B);
        end else if (bus.en) begin
            if (cnt_q == '0) begin
                state_d = nxt;
                cnt_d   = dwell(nxt);
                // Grant overrides a same-edge request so it is absorbed.
                if (nxt == WALK_A || nxt == WALK_B) begin
                    pend_d = 1'b0;
                    ack_d  = 1'b1;
                end
            end else begin
                cnt_d = cnt_q - 1'b1;
            end
        end

        // Outputs registered from the next state so they align with state_q.
        out_d = decode(state_d);
    end

    assign bus.ns_red   = out_q[6];
    assign bus.ns_amber = out_q[5];
    assign bus.ns_green = out_q[4];
    assign bus.ew_red   = out_q[3];
    assign bus.ew_amber = out_q[2];
    assign bus.ew_green = out_q[1];
    assign bus.ped_walk = out_q[0];
    assign bus.ped_ack  = ack_q;
    assign bus.state_o  = state_q;

endmodule

// File: tb/tb_junction_controller.sv
// ----------------------------------------------------------------------------
// tb_junction_controller
//   Directed testbench for junction_controller with short dwell times
//   (green 4, amber 2, red+amber 1, all-red 1, walk 3).
// ----------------------------------------------------------------------------
module tb_junction_controller;

    logic clk = 1'b0;
    logic rst_n;
    int   checks = 0;
    int   failures = 0;

    junction_controller_if bus ();

    junction_controller #(
        .T_GREEN     (4),
        .T_AMBER     (2),
        .T_RED_AMBER (1),
        .T_ALLRED    (1),
        .T_WALK      (3),
        .CNT_W       (8)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Expected {ns r,a,g, ew r,a,g} per state from the phase table.
    function automatic logic [5:0] exp_lamps(input int s);
        case (s)
            0:       exp_lamps = 6'b001_100;
            1:       exp_lamps = 6'b010_100;
            4:       exp_lamps = 6'b100_110;
            5:       exp_lamps = 6'b100_001;
            6:       exp_lamps = 6'b100_010;
            9:       exp_lamps = 6'b110_100;
            default: exp_lamps = 6'b100_100;
        endcase
    endfunction

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_now(input int s, input logic ack);
        logic [5:0] l;
        l = {bus.ns_red, bus.ns_amber, bus.ns_green, bus.ew_red, bus.ew_amber, bus.ew_green};
        chk("state_o", 8'(bus.state_o), 8'(s));
        chk("lamps", 8'(l), 8'(exp_lamps(s)));
        chk("ped_walk", 8'(bus.ped_walk), 8'((s == 3 || s == 8) ? 1 : 0));
        chk("ped_ack", 8'(bus.ped_ack), 8'(ack));
        chk("conflict", 8'(bus.ns_red | bus.ew_red), 8'd1);
        chk("walk_allred", 8'(!bus.ped_walk || l == 6'b100_100), 8'd1);
    endtask

    task automatic tick(input int s, input logic ack = 1'b0);
        @(posedge clk);
        #1;
        check_now(s, ack);
    endtask

    task automatic hold(input int s, input int n);
        for (int i = 0; i < n; i++) tick(s);
    endtask

    initial begin
        rst_n       = 1'b1;
        bus.en      = 1'b0;
        bus.ped_req = 1'b0;
        #2 rst_n = 1'b0;
        #1 check_now(7, 1'b0);
        @(posedge clk);
        #1 check_now(7, 1'b0);
        rst_n  = 1'b1;
        bus.en = 1'b1;

        // 1: plain cycle from reset
        tick(9); hold(0, 4); hold(1, 2); tick(2); tick(4);
        hold(5, 4); hold(6, 2); tick(7); tick(9);

        // 2: pulse during NS_GRN
        tick(0);
        bus.ped_req = 1'b1;
        tick(0);
        bus.ped_req = 1'b0;
        hold(0, 2); hold(1, 2); tick(2);
        tick(3, 1'b1); hold(3, 2);
        tick(4); hold(5, 4); hold(6, 2); tick(7); tick(9);

        // 3: request held through WALK_A -> one grant, re-latched after
        tick(0);
        bus.ped_req = 1'b1;
        hold(0, 3); hold(1, 2); tick(2);
        tick(3, 1'b1); hold(3, 2);
        tick(4);
        tick(5);
        bus.ped_req = 1'b0;
        hold(5, 3); hold(6, 2); tick(7);
        tick(8, 1'b1); hold(8, 2); tick(9);

        // 4: freeze in EW_GRN with a request during the freeze
        hold(0, 4); hold(1, 2); tick(2); tick(4);
        hold(5, 2);
        bus.en      = 1'b0;
        bus.ped_req = 1'b1;
        tick(5);
        bus.ped_req = 1'b0;
        hold(5, 4);
        bus.en = 1'b1;
        hold(5, 2); hold(6, 2); tick(7);
        tick(8, 1'b1); hold(8, 2); tick(9);

        // 5: asynchronous reset in EW_AMB with a pending request
        hold(0, 4); hold(1, 2); tick(2); tick(4);
        hold(5, 3);
        bus.ped_req = 1'b1;
        tick(5);
        bus.ped_req = 1'b0;
        tick(6);
        #3 rst_n = 1'b0;
        #1 check_now(7, 1'b0);
        @(posedge clk);
        #1 check_now(7, 1'b0);
        rst_n = 1'b1;
        tick(9); hold(0, 4); hold(1, 2); tick(2); tick(4);
        hold(5, 4); hold(6, 2); tick(7); tick(9);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
